// File: rtl/mc_ctrl_if.sv
`timescale 1ns/1ps
// Control bundle between the multi-cycle sequencer and the datapath.
// master = sequencer side (consumes IR fields and readies, drives strobes/selects).
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       im_rdy;
  logic       dm_rdy;
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;
  logic [4:0] aluop;
  logic       extop;
  logic [1:0] RegDst;
  logic       ALUSrc;
  logic [1:0] MemtoReg;
  logic [1:0] s;
  logic [2:0] state;
  logic       retire;
  logic       illegal;

  modport master (
    input  op, funct, zero, im_rdy, dm_rdy,
    output pc_write, ir_write, reg_write, mem_write, aluop, extop, RegDst, ALUSrc,
           MemtoReg, s, state, retire, illegal
  );

  modport slave (
    output op, funct, zero, im_rdy, dm_rdy,
    input  pc_write, ir_write, reg_write, mem_write, aluop, extop, RegDst, ALUSrc,
           MemtoReg, s, state, retire, illegal
  );
endinterface

// File: rtl/mc_ctrl.sv
`timescale 1ns/1ps
// Multi-cycle MIPS control sequencer: FETCH -> DECODE -> EXE -> MEM -> WB.
// Strobes and selects are a combinational decode of the registered state
// qualified by op/funct; strobes are forced low while reset is asserted.
module mc_ctrl (
  input  logic      clock,
  input  logic      reset,
  mc_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExe    = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnJr    = 6'h08;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSubu  = 6'h23;
  localparam logic [5:0] FnAnd   = 6'h24;
  localparam logic [5:0] FnOr    = 6'h25;
  localparam logic [5:0] FnSlt   = 6'h2a;

  state_e state_q;

  logic is_r, is_r_alu, is_jr, is_j, is_jal, is_beq;
  logic is_addiu, is_ori, is_lui, is_lw, is_sw, legal;

  // zero is consumed by npc, not by the sequencer.
  logic unused_zero;
  assign unused_zero = bus.zero;

  // Instruction class decode from the IR fields.
  always_comb begin
    is_r     = (bus.op == OpRtype);
    is_r_alu = is_r && ((bus.funct == FnAddu) || (bus.funct == FnSubu) ||
                        (bus.funct == FnAnd)  || (bus.funct == FnOr)   ||
                        (bus.funct == FnSlt));
    is_jr    = is_r && (bus.funct == FnJr);
    is_j     = (bus.op == OpJ);
    is_jal   = (bus.op == OpJal);
    is_beq   = (bus.op == OpBeq);
    is_addiu = (bus.op == OpAddiu);
    is_ori   = (bus.op == OpOri);
    is_lui   = (bus.op == OpLui);
    is_lw    = (bus.op == OpLw);
    is_sw    = (bus.op == OpSw);
    legal    = is_r_alu | is_jr | is_j | is_jal | is_beq | is_addiu | is_ori |
               is_lui | is_lw | is_sw;
  end

  // State register with next-state selection; unused encodings recover to FETCH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      case (state_q)
        StFetch: begin
          if (bus.im_rdy) state_q <= StDecode;
        end
        StDecode: begin
          if (is_j || is_jal || is_jr || !legal) state_q <= StFetch;
          else                                   state_q <= StExe;
        end
        StExe: begin
          if (is_beq)              state_q <= StFetch;
          else if (is_lw || is_sw) state_q <= StMem;
          else                     state_q <= StWb;
        end
        StMem: begin
          if (bus.dm_rdy) state_q <= is_lw ? StWb : StFetch;
        end
        StWb:    state_q <= StFetch;
        default: state_q <= StFetch;
      endcase
    end
  end

  // Datapath selects: held at their decoded values in every state.
  always_comb begin
    bus.aluop = 5'd0;
    if (is_r) begin
      case (bus.funct)
        FnSubu:  bus.aluop = 5'd1;
        FnAnd:   bus.aluop = 5'd2;
        FnOr:    bus.aluop = 5'd3;
        FnSlt:   bus.aluop = 5'd4;
        default: bus.aluop = 5'd0;
      endcase
    end else begin
      case (bus.op)
        OpBeq:   bus.aluop = 5'd1;
        OpOri:   bus.aluop = 5'd3;
        OpLui:   bus.aluop = 5'd5;
        default: bus.aluop = 5'd0;
      endcase
    end

    bus.extop  = is_addiu | is_lw | is_sw | is_beq;
    bus.ALUSrc = is_addiu | is_ori | is_lui | is_lw | is_sw;

    if (is_jal)    bus.RegDst = 2'b10;
    else if (is_r) bus.RegDst = 2'b01;
    else           bus.RegDst = 2'b00;

    if (is_jal)     bus.MemtoReg = 2'b00;
    else if (is_lw) bus.MemtoReg = 2'b10;
    else            bus.MemtoReg = 2'b01;

    if (is_j || is_jal) bus.s = 2'b10;
    else if (is_jr)     bus.s = 2'b11;
    else if (is_beq)    bus.s = 2'b01;
    else                bus.s = 2'b00;
  end

  // Per-state write strobes; all held low while reset is asserted.
  always_comb begin
    bus.pc_write  = 1'b0;
    bus.ir_write  = 1'b0;
    bus.reg_write = 1'b0;
    bus.mem_write = 1'b0;
    bus.illegal   = 1'b0;
    if (reset) begin
      case (state_q)
        StFetch: bus.ir_write = bus.im_rdy;
        StDecode: begin
          if (is_j || is_jr) begin
            bus.pc_write = 1'b1;
          end else if (is_jal) begin
            bus.pc_write  = 1'b1;
            bus.reg_write = 1'b1;
          end else if (!legal) begin
            bus.pc_write = 1'b1;
            bus.illegal  = 1'b1;
          end
        end
        StExe: bus.pc_write = is_beq;
        StMem: begin
          // sw keeps mem_write up across the wait; DM commits on dm_rdy.
          bus.mem_write = is_sw;
          bus.pc_write  = is_sw & bus.dm_rdy;
        end
        StWb: begin
          bus.reg_write = 1'b1;
          bus.pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.retire = bus.pc_write;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for mc_ctrl: vector table plus scoreboard queue.
module tb_mc_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       im;
    logic       dm;
    logic [2:0] st;
    logic [5:0] stb;   // {pc_write, ir_write, reg_write, mem_write, retire, illegal}
    logic [12:0] sel;  // {aluop, extop, RegDst, ALUSrc, MemtoReg, s}
    logic [12:0] msk;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_IR   = 6'b010000;
  localparam logic [5:0] S_WB   = 6'b101010;
  localparam logic [5:0] S_PC   = 6'b100010;
  localparam logic [5:0] S_SWW  = 6'b000100;
  localparam logic [5:0] S_SWC  = 6'b100110;
  localparam logic [5:0] S_ILL  = 6'b100011;

  localparam logic [12:0] M_ALL  = 13'h1fff;
  localparam logic [12:0] M_CORE = 13'b11111_1_00_1_00_11;
  localparam logic [12:0] M_S    = 13'h0003;

  function automatic logic [12:0] sel(input logic [4:0] alu, input logic ext,
                                      input logic [1:0] rd, input logic src,
                                      input logic [1:0] m2r, input logic [1:0] s);
    return {alu, ext, rd, src, m2r, s};
  endfunction

  task automatic add(input string name, input logic rst, input logic [5:0] op,
                     input logic [5:0] funct, input logic im, input logic dm,
                     input logic [2:0] st, input logic [5:0] stb,
                     input logic [12:0] sv, input logic [12:0] msk);
    vec_t v;
    v.name = name; v.rst = rst; v.op = op; v.funct = funct; v.im = im; v.dm = dm;
    v.st = st; v.stb = stb; v.sel = sv; v.msk = msk;
    vecs.push_back(v);
  endtask

  // Four-cycle ALU instruction: FETCH, DECODE, EXE, WB.
  task automatic add_alu(input string name, input logic [5:0] op, input logic [5:0] funct,
                         input logic [12:0] sv);
    add({name, "_f"}, 1, op, funct, 1, 1, 3'd0, S_IR,   sv, M_ALL);
    add({name, "_d"}, 1, op, funct, 1, 1, 3'd1, S_NONE, sv, M_ALL);
    add({name, "_e"}, 1, op, funct, 1, 1, 3'd2, S_NONE, sv, M_ALL);
    add({name, "_w"}, 1, op, funct, 1, 1, 3'd4, S_WB,   sv, M_ALL);
  endtask

  task automatic check();
    vec_t e;
    logic [5:0]  got_stb;
    logic [12:0] got_sel;
    e = sb.pop_front();
    got_stb = {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write,
               bus.retire, bus.illegal};
    got_sel = {bus.aluop, bus.extop, bus.RegDst, bus.ALUSrc, bus.MemtoReg, bus.s};
    n_vec++;
    if (bus.state !== e.st || got_stb !== e.stb ||
        (got_sel & e.msk) !== (e.sel & e.msk)) begin
      n_fail++;
      $display("FAIL %s: got state=%0d strobes=%b sel=%b, expected state=%0d strobes=%b sel=%b mask=%b",
               e.name, bus.state, got_stb, got_sel, e.st, e.stb, e.sel, e.msk);
    end
  endtask

  // Drive one cycle, queue its expectation, compare mid-cycle, advance past the edge.
  task automatic apply(input vec_t v);
    reset      = v.rst;
    bus.op     = v.op;
    bus.funct  = v.funct;
    bus.im_rdy = v.im;
    bus.dm_rdy = v.dm;
    sb.push_back(v);
    #3;
    check();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [12:0] s_addu, s_lw, s_sw, s_beq, s_jal;
    vec_t v;
    s_addu = sel(5'd0, 1'b0, 2'b01, 1'b0, 2'b01, 2'b00);
    s_lw   = sel(5'd0, 1'b1, 2'b00, 1'b1, 2'b10, 2'b00);
    s_sw   = sel(5'd0, 1'b1, 2'b00, 1'b1, 2'b01, 2'b00);
    s_beq  = sel(5'd1, 1'b1, 2'b00, 1'b0, 2'b01, 2'b01);
    s_jal  = sel(5'd0, 1'b0, 2'b10, 1'b0, 2'b00, 2'b10);

    bus.zero = 1'b0;
    bus.op = 6'h00; bus.funct = 6'h21; bus.im_rdy = 1'b1; bus.dm_rdy = 1'b1;

    // Reset held three cycles with im_rdy high, then release.
    for (int i = 0; i < 3; i++)
      add("reset", 0, 6'h00, 6'h21, 1, 1, 3'd0, S_NONE, s_addu, M_S);
    add("rel_fetch", 1, 6'h00, 6'h21, 1, 1, 3'd0, S_IR, s_addu, M_ALL);
    add("addu_d", 1, 6'h00, 6'h21, 1, 1, 3'd1, S_NONE, s_addu, M_ALL);
    add("addu_e", 1, 6'h00, 6'h21, 1, 1, 3'd2, S_NONE, s_addu, M_ALL);
    add("addu_w", 1, 6'h00, 6'h21, 1, 1, 3'd4, S_WB,   s_addu, M_ALL);

    // FETCH stall on im_rdy, then lw with two MEM wait cycles.
    add("lw_fstall", 1, 6'h23, 6'h00, 0, 0, 3'd0, S_NONE, s_lw, M_ALL);
    add("lw_f",  1, 6'h23, 6'h00, 1, 0, 3'd0, S_IR,   s_lw, M_ALL);
    add("lw_d",  1, 6'h23, 6'h00, 1, 0, 3'd1, S_NONE, s_lw, M_ALL);
    add("lw_e",  1, 6'h23, 6'h00, 1, 0, 3'd2, S_NONE, s_lw, M_ALL);
    add("lw_m0", 1, 6'h23, 6'h00, 1, 0, 3'd3, S_NONE, s_lw, M_ALL);
    add("lw_m1", 1, 6'h23, 6'h00, 1, 0, 3'd3, S_NONE, s_lw, M_ALL);
    add("lw_m2", 1, 6'h23, 6'h00, 1, 1, 3'd3, S_NONE, s_lw, M_ALL);
    add("lw_w",  1, 6'h23, 6'h00, 1, 1, 3'd4, S_WB,   s_lw, M_ALL);

    // sw with no wait, sw with one wait, then beq.
    add("sw_f", 1, 6'h2b, 6'h00, 1, 1, 3'd0, S_IR,   s_sw, M_CORE);
    add("sw_d", 1, 6'h2b, 6'h00, 1, 1, 3'd1, S_NONE, s_sw, M_CORE);
    add("sw_e", 1, 6'h2b, 6'h00, 1, 1, 3'd2, S_NONE, s_sw, M_CORE);
    add("sw_m", 1, 6'h2b, 6'h00, 1, 1, 3'd3, S_SWC,  s_sw, M_CORE);
    add("sw2_f",  1, 6'h2b, 6'h00, 1, 0, 3'd0, S_IR,   s_sw, M_CORE);
    add("sw2_d",  1, 6'h2b, 6'h00, 1, 0, 3'd1, S_NONE, s_sw, M_CORE);
    add("sw2_e",  1, 6'h2b, 6'h00, 1, 0, 3'd2, S_NONE, s_sw, M_CORE);
    add("sw2_mw", 1, 6'h2b, 6'h00, 1, 0, 3'd3, S_SWW,  s_sw, M_CORE);
    add("sw2_mc", 1, 6'h2b, 6'h00, 1, 1, 3'd3, S_SWC,  s_sw, M_CORE);
    add("beq_f", 1, 6'h04, 6'h00, 1, 1, 3'd0, S_IR,   s_beq, M_CORE);
    add("beq_d", 1, 6'h04, 6'h00, 1, 1, 3'd1, S_NONE, s_beq, M_CORE);
    add("beq_e", 1, 6'h04, 6'h00, 1, 1, 3'd2, S_PC,   s_beq, M_CORE);

    // Jumps: two cycles each.
    add("jal_f", 1, 6'h03, 6'h00, 1, 1, 3'd0, S_IR, s_jal, M_ALL);
    add("jal_d", 1, 6'h03, 6'h00, 1, 1, 3'd1, S_WB, s_jal, M_ALL);
    add("jr_f",  1, 6'h00, 6'h08, 1, 1, 3'd0, S_IR, 13'h0003, M_S);
    add("jr_d",  1, 6'h00, 6'h08, 1, 1, 3'd1, S_PC, 13'h0003, M_S);
    add("j_f",   1, 6'h02, 6'h00, 1, 1, 3'd0, S_IR, 13'h0002, M_S);
    add("j_d",   1, 6'h02, 6'h00, 1, 1, 3'd1, S_PC, 13'h0002, M_S);

    // Undecoded op and undecoded R-type funct.
    add("ill_f",  1, 6'h3f, 6'h00, 1, 1, 3'd0, S_IR,  13'h0000, M_S);
    add("ill_d",  1, 6'h3f, 6'h00, 1, 1, 3'd1, S_ILL, 13'h0000, M_S);
    add("illr_f", 1, 6'h00, 6'h3f, 1, 1, 3'd0, S_IR,  13'h0000, M_S);
    add("illr_d", 1, 6'h00, 6'h3f, 1, 1, 3'd1, S_ILL, 13'h0000, M_S);

    // Remaining ALU ops.
    add_alu("subu",  6'h00, 6'h23, sel(5'd1, 1'b0, 2'b01, 1'b0, 2'b01, 2'b00));
    add_alu("and",   6'h00, 6'h24, sel(5'd2, 1'b0, 2'b01, 1'b0, 2'b01, 2'b00));
    add_alu("or",    6'h00, 6'h25, sel(5'd3, 1'b0, 2'b01, 1'b0, 2'b01, 2'b00));
    add_alu("slt",   6'h00, 6'h2a, sel(5'd4, 1'b0, 2'b01, 1'b0, 2'b01, 2'b00));
    add_alu("addiu", 6'h09, 6'h00, sel(5'd0, 1'b1, 2'b00, 1'b1, 2'b01, 2'b00));
    add_alu("ori",   6'h0d, 6'h00, sel(5'd3, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00));
    add_alu("lui",   6'h0f, 6'h00, sel(5'd5, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00));

    // Definite asserting edge on reset, then run the table.
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Reset during a lw MEM stall aborts at once; reg_write must stay low.
    v.rst = 1; v.op = 6'h23; v.funct = 6'h00; v.im = 1; v.dm = 0;
    v.sel = s_lw; v.msk = M_ALL;
    v.name = "abort_f"; v.st = 3'd0; v.stb = S_IR;   apply(v);
    v.name = "abort_d"; v.st = 3'd1; v.stb = S_NONE; apply(v);
    v.name = "abort_e"; v.st = 3'd2; v.stb = S_NONE; apply(v);
    v.name = "abort_m"; v.st = 3'd3; v.stb = S_NONE; apply(v);
    v.name = "abort_rst0"; v.rst = 0; v.st = 3'd0; v.stb = S_NONE; apply(v);
    v.name = "abort_rst1"; v.dm = 1; apply(v);
    v.name = "abort_rel"; v.rst = 1; v.st = 3'd0; v.stb = S_IR; apply(v);
    v.name = "abort_d2"; v.st = 3'd1; v.stb = S_NONE; apply(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
